wb_timer: RTL and testbench

Wishbone B3 classic slave holding `N_TIMERS` independent 32-bit compare timers. It sits on the core's Wishbone bus beside `memory_wb`, selected by the external address decoder. It drives `o_irq` straight into the core's `i_int_source` lines. Firmware programs enable, prescale, compare value and auto-reload. A timer flags and optionally interrupts when its count reaches compare.

---
 rtl/wb_timer.sv | 169 ++++++++++++++++
 tb/tb_wb_timer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_timer.sv
// Wishbone B3 classic slave with N_TIMERS 32-bit compare timers, each with a prescaler,
// one-shot or auto-reload operation, a sticky MATCH flag and a level interrupt.
module wb_timer #(
    parameter int unsigned N_TIMERS   = 2,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wb_cyc,
    input  logic                i_wb_stb,
    input  logic                i_wb_we,
    input  logic [3:0]          i_wb_sel,
    input  logic [31:0]         i_wb_adr,
    input  logic [31:0]         i_wb_dat,
    output logic [31:0]         o_wb_dat,
    output logic                o_wb_ack,
    output logic [N_TIMERS-1:0] o_irq
);

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_COUNT   = 2'd1;
    localparam logic [1:0] REG_COMPARE = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    logic        req;
    logic        wr;
    logic [1:0]  tidx;
    logic [1:0]  rsel;
    logic [31:0] rd_data;
    logic [31:0] rd_ctrl    [4];
    logic [31:0] rd_count   [4];
    logic [31:0] rd_compare [4];
    logic [31:0] rd_status  [4];
    logic        unused_adr;

    // The ack itself masks the request so every transfer takes exactly two clocks.
    assign req        = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    assign wr         = req & i_wb_we;
    assign tidx       = i_wb_adr[5:4];
    assign rsel       = i_wb_adr[3:2];
    assign unused_adr = ^{i_wb_adr[31:6], i_wb_adr[1:0]};

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_timer
        if (i < N_TIMERS) begin : g_on
            logic                  en_q, en_d, reload_q, reload_d, ie_q, ie_d, match_q, match_d;
            logic [PRESCALE_W-1:0] prescale_q, prescale_d, pcnt_q, pcnt_d;
            logic [31:0]           count_q, count_d, compare_q, compare_d;
            logic                  sel_me, tick, hit;

            assign sel_me = wr & (tidx == 2'(i));
            assign tick   = en_q & (pcnt_q == prescale_q);
            assign hit    = tick & (count_q == compare_q);

            always_comb begin
                en_d       = en_q;
                reload_d   = reload_q;
                ie_d       = ie_q;
                prescale_d = prescale_q;
                count_d    = count_q;
                compare_d  = compare_q;
                match_d    = match_q | hit;
                pcnt_d     = pcnt_q;

                if (tick) begin
                    pcnt_d = '0;
                    if (hit) begin
                        if (reload_q) count_d = '0;
                        else          en_d    = 1'b0;
                    end else begin
                        count_d = count_q + 32'd1;
                    end
                end else if (en_q) begin
                    pcnt_d = pcnt_q + PRESCALE_W'(1);
                end

                // Bus writes override the tick result for the register they touch.
                if (sel_me) begin
                    unique case (rsel)
                        REG_CTRL: begin
                            if (i_wb_sel[0]) begin
                                en_d     = i_wb_dat[0];
                                reload_d = i_wb_dat[1];
                                ie_d     = i_wb_dat[2];
                            end
                            for (int j = 0; j < PRESCALE_W; j++) begin
                                if (i_wb_sel[(8 + j) / 8]) prescale_d[j] = i_wb_dat[8 + j];
                            end
                        end
                        REG_COUNT: begin
                            count_d = byte_merge(count_q, i_wb_dat, i_wb_sel);
                            if (|i_wb_sel) pcnt_d = '0;
                        end
                        REG_COMPARE: compare_d = byte_merge(compare_q, i_wb_dat, i_wb_sel);
                        REG_STATUS: begin
                            if (i_wb_sel[0] & i_wb_dat[0] & ~hit) match_d = 1'b0;
                        end
                    endcase
                end

                if (!en_d) pcnt_d = '0;
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    en_q       <= 1'b0;
                    reload_q   <= 1'b0;
                    ie_q       <= 1'b0;
                    match_q    <= 1'b0;
                    prescale_q <= '0;
                    pcnt_q     <= '0;
                    count_q    <= '0;
                    compare_q  <= '1;
                end else begin
                    en_q       <= en_d;
                    reload_q   <= reload_d;
                    ie_q       <= ie_d;
                    match_q    <= match_d;
                    prescale_q <= prescale_d;
                    pcnt_q     <= pcnt_d;
                    count_q    <= count_d;
                    compare_q  <= compare_d;
                end
            end

            assign rd_ctrl[i]    = 32'({prescale_q, 5'd0, ie_q, reload_q, en_q});
            assign rd_count[i]   = count_q;
            assign rd_compare[i] = compare_q;
            assign rd_status[i]  = {31'd0, match_q};
            assign o_irq[i]      = match_q & ie_q;
        end else begin : g_off
            assign rd_ctrl[i]    = '0;
            assign rd_count[i]   = '0;
            assign rd_compare[i] = '0;
            assign rd_status[i]  = '0;
        end
    end

    always_comb begin
        rd_data = '0;
        unique case (rsel)
            REG_CTRL:    rd_data = rd_ctrl[tidx];
            REG_COUNT:   rd_data = rd_count[tidx];
            REG_COMPARE: rd_data = rd_compare[tidx];
            REG_STATUS:  rd_data = rd_status[tidx];
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wb_ack <= 1'b0;
            o_wb_dat <= '0;
        end else begin
            o_wb_ack <= req;
            o_wb_dat <= (req & ~i_wb_we) ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_wb_timer.sv
// Bench for wb_timer: directed bus transfers with literal expectations, plus a behavioural
// register/timer model compared against ack, read data and irq on every falling edge.
module tb_wb_timer;

    localparam int NT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cyc, stb, we;
    logic [3:0]    sel;
    logic [31:0]   adr, wdat, rdat;
    logic          ack;
    logic [NT-1:0] irq;

    int n_checks = 0;
    int n_fail   = 0;

    wb_timer #(
        .N_TIMERS  (NT),
        .PRESCALE_W(8)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_wb_cyc(cyc),
        .i_wb_stb(stb),
        .i_wb_we (we),
        .i_wb_sel(sel),
        .i_wb_adr(adr),
        .i_wb_dat(wdat),
        .o_wb_dat(rdat),
        .o_wb_ack(ack),
        .o_irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Behavioural model state, one entry per timer.
    logic [31:0] m_cnt [NT];
    logic [31:0] m_cmp [NT];
    logic [7:0]  m_ps  [NT];
    logic [7:0]  m_pc  [NT];
    logic        m_en  [NT];
    logic        m_ar  [NT];
    logic        m_ie  [NT];
    logic        m_match [NT];
    logic          e_ack;
    logic [31:0]   e_dat;
    logic [NT-1:0] e_irq;
    logic          model_on = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic model_step();
        logic        req, hit;
        int          t, r;
        logic [31:0] rd;
        if (rst) begin
            model_on = 1'b1;
            e_ack = 1'b0;
            e_dat = '0;
            e_irq = '0;
            for (int k = 0; k < NT; k++) begin
                m_cnt[k] = 0; m_cmp[k] = 32'hFFFF_FFFF; m_ps[k] = 0; m_pc[k] = 0;
                m_en[k] = 0; m_ar[k] = 0; m_ie[k] = 0; m_match[k] = 0;
            end
            return;
        end
        req = cyc && stb && !e_ack;
        t = int'(adr[5:4]);
        r = int'(adr[3:2]);
        rd = '0;
        if (t < NT) begin
            case (r)
                0: rd = {16'd0, m_ps[t], 5'd0, m_ie[t], m_ar[t], m_en[t]};
                1: rd = m_cnt[t];
                2: rd = m_cmp[t];
                default: rd = {31'd0, m_match[t]};
            endcase
        end
        e_dat = (req && !we) ? rd : 32'd0;
        e_ack = req;
        for (int k = 0; k < NT; k++) begin
            hit = 1'b0;
            if (m_en[k]) begin
                if (m_pc[k] == m_ps[k]) begin
                    m_pc[k] = 0;
                    if (m_cnt[k] == m_cmp[k]) begin
                        hit = 1'b1;
                        m_match[k] = 1'b1;
                        if (m_ar[k]) m_cnt[k] = 0;
                        else         m_en[k]  = 1'b0;
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end else begin
                    m_pc[k] = m_pc[k] + 1;
                end
            end
            if (req && we && t == k) begin
                case (r)
                    0: begin
                        if (sel[0]) begin
                            m_en[k] = wdat[0]; m_ar[k] = wdat[1]; m_ie[k] = wdat[2];
                        end
                        if (sel[1]) m_ps[k] = wdat[15:8];
                    end
                    1: if (sel != 4'd0) begin
                        m_cnt[k] = merge(m_cnt[k], wdat, sel);
                        m_pc[k]  = 0;
                    end
                    2: m_cmp[k] = merge(m_cmp[k], wdat, sel);
                    default: if (sel[0] && wdat[0] && !hit) m_match[k] = 1'b0;
                endcase
            end
            if (!m_en[k]) m_pc[k] = 0;
            e_irq[k] = m_match[k] && m_ie[k];
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (model_on) begin
            check("cyc_ack", 32'(ack), 32'(e_ack));
            check("cyc_rdata", rdat, e_dat);
            check("cyc_irq", 32'(irq), 32'(e_irq));
        end
    end

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] q);
        int lat;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack && lat < 8);
        check("ack_latency", 32'(lat), 32'd1);
        q = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] q;
        bus(1'b1, a, d, s, q);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] want);
        logic [31:0] q;
        bus(1'b0, a, 32'd0, 4'd0, q);
        check(name, q, want);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'd0; adr = '0; wdat = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset values
        rd_chk("rst_compare0", 32'h08, 32'hFFFF_FFFF);
        rd_chk("rst_ctrl0",    32'h00, 32'h0);
        rd_chk("rst_count0",   32'h04, 32'h0);
        rd_chk("rst_status0",  32'h0C, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);

        // Timer 0: compare 5, prescale 0, auto-reload, irq enabled
        wr(32'h08, 32'd5, 4'hF);
        wr(32'h00, 32'h7, 4'hF);
        repeat (5) @(negedge clk);
        check("t0_irq_before_match", 32'(irq[0]), 32'd0);
        @(negedge clk);
        check("t0_irq_at_match", 32'(irq[0]), 32'd1);
        rd_chk("t0_count_after_reload", 32'h04, 32'd1);
        wr(32'h0C, 32'h1, 4'h1);
        check("t0_irq_w1c", 32'(irq[0]), 32'd0);
        @(negedge clk);
        check("t0_irq_still_clear", 32'(irq[0]), 32'd0);
        @(negedge clk);
        check("t0_irq_second_match", 32'(irq[0]), 32'd1);
        wr(32'h00, 32'h0, 4'hF);
        wr(32'h0C, 32'h1, 4'h1);

        // Timer 1: prescale 3, compare 2, one-shot
        wr(32'h18, 32'd2, 4'hF);
        wr(32'h10, 32'h305, 4'hF);
        repeat (4) @(negedge clk);
        rd_chk("t1_count_first_tick", 32'h14, 32'd1);
        repeat (5) @(negedge clk);
        check("t1_irq_before_match", 32'(irq[1]), 32'd0);
        @(negedge clk);
        check("t1_irq_at_match", 32'(irq[1]), 32'd1);
        rd_chk("t1_ctrl_oneshot", 32'h10, 32'h304);
        rd_chk("t1_count_hold", 32'h14, 32'd2);
        wr(32'h1C, 32'h1, 4'h1);
        check("t1_irq_w1c", 32'(irq[1]), 32'd0);

        // Byte enables and out-of-range timer index
        wr(32'h04, 32'h0, 4'hF);
        wr(32'h04, 32'h1122_3344, 4'b0101);
        rd_chk("byte_write", 32'h04, 32'h0022_0044);
        wr(32'h04, 32'hFFFF_FFFF, 4'h0);
        rd_chk("sel_zero_write", 32'h04, 32'h0022_0044);
        wr(32'h34, 32'hDEAD_BEEF, 4'hF);
        rd_chk("t3_count", 32'h34, 32'h0);
        rd_chk("t3_ctrl", 32'h30, 32'h0);
        rd_chk("t1_count_no_alias", 32'h14, 32'd2);

        // COUNT write on a tick edge: write wins
        wr(32'h08, 32'h100, 4'hF);
        wr(32'h00, 32'h301, 4'hF);
        repeat (6) @(negedge clk);
        wr(32'h04, 32'h10, 4'hF);
        rd_chk("count_write_on_tick", 32'h04, 32'h10);
        wr(32'h00, 32'h0, 4'hF);

        // W1C on the match edge: set wins
        wr(32'h08, 32'd5, 4'hF);
        wr(32'h04, 32'd0, 4'hF);
        wr(32'h00, 32'h7, 4'hF);
        repeat (10) @(negedge clk);
        wr(32'h0C, 32'h1, 4'h1);
        check("w1c_on_match_irq", 32'(irq[0]), 32'd1);
        rd_chk("w1c_on_match_status", 32'h0C, 32'd1);
        wr(32'h00, 32'h0, 4'hF);
        wr(32'h0C, 32'h1, 4'h1);

        // Wrap from 0xFFFFFFFF to 0 does not match
        wr(32'h08, 32'd3, 4'hF);
        wr(32'h04, 32'hFFFF_FFFF, 4'hF);
        wr(32'h00, 32'h5, 4'hF);
        rd_chk("wrap_count", 32'h04, 32'd0);
        check("wrap_no_match", 32'(irq[0]), 32'd0);
        repeat (2) @(negedge clk);
        check("wrap_irq_before", 32'(irq[0]), 32'd0);
        @(negedge clk);
        check("wrap_irq_match", 32'(irq[0]), 32'd1);
        rd_chk("wrap_ctrl_oneshot", 32'h00, 32'h4);
        rd_chk("wrap_count_hold", 32'h04, 32'd3);

        // Reset during an active strobe with timers running
        wr(32'h18, 32'd2, 4'hF);
        wr(32'h10, 32'h7, 4'hF);
        repeat (5) @(negedge clk);
        check("pre_reset_irq", 32'(irq), 32'h3);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h14; rst = 1'b1;
        @(negedge clk);
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_dat", rdat, 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        cyc = 1'b0; stb = 1'b0; rst = 1'b0;
        rd_chk("midrst_compare1", 32'h18, 32'hFFFF_FFFF);
        rd_chk("midrst_ctrl1", 32'h10, 32'h0);
        rd_chk("midrst_count1", 32'h14, 32'h0);
        rd_chk("midrst_status0", 32'h0C, 32'h0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
